jam_param: RTL and testbench

Parametrised successor of the job-assignment (JAM) solver. It loads an N×N worker/job cost matrix through an address/data fetch port and exhaustively enumerates all N! assignments in lexicographic order, one per cycle. It reports the minimum total cost, the number of assignments achieving it, and the lexicographically first optimal assignment. It sits behind the cost-memory testbench/ROM and adds a START/BUSY handshake for back-to-back runs.

---
 rtl/jam_param_pkg.sv | 27 ++
 rtl/jam_param_if.sv | 32 +++
 rtl/jam_param_next_perm.sv | 57 +++++
 rtl/jam_param.sv | 160 ++++++++++++++++
 tb/tb_jam_param.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/jam_param_pkg.sv
// Shared state encodings and width helpers for the job-assignment solver.
package jam_pkg;

    typedef logic [1:0] jam_state_t;

    localparam jam_state_t IDLE = 2'd0;
    localparam jam_state_t LOAD = 2'd1;
    localparam jam_state_t EVAL = 2'd2;
    localparam jam_state_t DONE = 2'd3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Index width never drops below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned sum_w(input int unsigned n, input int unsigned cw);
        return cw + clog2(n);
    endfunction

endpackage

// File: rtl/jam_param_if.sv
// Cost-fetch, run handshake and result bus of the job-assignment solver.
interface jam_param_if #(
    parameter int unsigned N   = 8,
    parameter int unsigned CW  = 7,
    parameter int unsigned MCW = 16
);
    import jam_pkg::*;

    localparam int unsigned IW = idx_w(N);
    localparam int unsigned SW = sum_w(N, CW);

    logic            START;
    logic [IW-1:0]   W;
    logic [IW-1:0]   J;
    logic [CW-1:0]   Cost;
    logic            BUSY;
    logic            Valid;
    logic [SW-1:0]   MinCost;
    logic [MCW-1:0]  MatchCount;
    logic [N*IW-1:0] BestJob;

    modport master (
        input  START, Cost,
        output W, J, BUSY, Valid, MinCost, MatchCount, BestJob
    );

    modport slave (
        output START, Cost,
        input  W, J, BUSY, Valid, MinCost, MatchCount, BestJob
    );

endinterface

// File: rtl/jam_param_next_perm.sv
// Combinational next-lexicographic-permutation step; last_o flags the descending permutation.
module jam_next_perm #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N*IW-1:0] perm_i,
    output logic [N*IW-1:0] perm_o,
    output logic            last_o
);
    logic [IW-1:0] p [N];
    logic [IW-1:0] q [N];
    logic [IW-1:0] pk, pl;
    logic          found;
    int unsigned   k, l;

    // Pivot/successor selection and the tail reversal are written as compare-and-select
    // loops so no element is addressed by a run-time index.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) p[i] = perm_i[i*IW +: IW];

        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i + 1 < N; i++) begin
            if (p[i] < p[i+1]) begin
                found = 1'b1;
                k     = i;
            end
        end

        pk = '0;
        for (int unsigned i = 0; i < N; i++) if (i == k) pk = p[i];

        l  = 0;
        pl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i > k && p[i] > pk) begin
                l  = i;
                pl = p[i];
            end
        end

        for (int unsigned i = 0; i < N; i++) begin
            q[i] = p[i];
            if (found && i == k) begin
                q[i] = pl;
            end else if (found && i > k) begin
                for (int unsigned j = 0; j < N; j++)
                    if (j + i == N + k) q[i] = (j == l) ? pk : p[j];
            end
        end

        perm_o = '0;
        for (int unsigned i = 0; i < N; i++) perm_o[i*IW +: IW] = q[i];
        last_o = !found;
    end

endmodule

// File: rtl/jam_param.sv
// Exhaustive job-assignment solver: loads an NxN cost matrix, scores all N! assignments
// one per cycle, and reports the minimum cost, its tie count and the first optimum.
module jam_param
    import jam_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned CW  = 7,
    parameter int unsigned MCW = 16
) (
    input logic         CLK,
    input logic         RST,
    jam_param_if.master bus
);
    localparam int unsigned IW = idx_w(N);
    localparam int unsigned SW = sum_w(N, CW);

    jam_state_t      state_q, state_d;
    logic [IW-1:0]   w_q, w_d, j_q, j_d;
    logic            busy_q, busy_d, valid_q, valid_d;
    logic [SW-1:0]   min_out_q, min_out_d;
    logic [MCW-1:0]  cnt_out_q, cnt_out_d;
    logic [N*IW-1:0] best_out_q, best_out_d;

    logic [CW-1:0]   cost_q [N][N];
    logic [N*IW-1:0] perm_q, perm_d, perm_nxt, ident;
    logic [SW-1:0]   min_q, min_d, sum;
    logic [MCW-1:0]  cnt_q, cnt_d;
    logic [N*IW-1:0] best_q, best_d;
    logic            perm_last, load_last;

    jam_next_perm #(.N(N), .IW(IW)) u_next (
        .perm_i (perm_q),
        .perm_o (perm_nxt),
        .last_o (perm_last)
    );

    always_comb begin
        ident = '0;
        for (int unsigned i = 0; i < N; i++) ident[i*IW +: IW] = IW'(i);
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
                if (perm_q[i*IW +: IW] == IW'(j)) sum = sum + SW'(cost_q[i][j]);
    end

    assign load_last = (w_q == IW'(N-1)) && (j_q == IW'(N-1));

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        j_d        = j_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        min_out_d  = min_out_q;
        cnt_out_d  = cnt_out_q;
        best_out_d = best_out_q;
        perm_d     = perm_q;
        min_d      = min_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = LOAD;
                    w_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                if (j_q == IW'(N-1)) begin
                    j_d = '0;
                    w_d = w_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                if (load_last) begin
                    state_d = EVAL;
                    w_d     = '0;
                    perm_d  = ident;
                    min_d   = '1;
                    cnt_d   = '0;
                end
            end
            EVAL: begin
                if (sum < min_q) begin
                    min_d  = sum;
                    cnt_d  = MCW'(1);
                    best_d = perm_q;
                end else if (sum == min_q && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                perm_d = perm_nxt;
                if (perm_last) state_d = DONE;
            end
            DONE: begin
                min_out_d  = min_q;
                cnt_out_d  = cnt_q;
                best_out_d = best_q;
                valid_d    = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
                if (bus.START) begin
                    state_d = LOAD;
                    w_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            w_q        <= '0;
            j_q        <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            min_out_q  <= '0;
            cnt_out_q  <= '0;
            best_out_q <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            j_q        <= j_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            min_out_q  <= min_out_d;
            cnt_out_q  <= cnt_out_d;
            best_out_q <= best_out_d;
        end
    end

    // Datapath state is re-initialised at the end of every load, so it carries no reset.
    always_ff @(posedge CLK) begin
        perm_q <= perm_d;
        min_q  <= min_d;
        cnt_q  <= cnt_d;
        best_q <= best_d;
        if (state_q == LOAD) begin
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned j = 0; j < N; j++)
                    if (w_q == IW'(i) && j_q == IW'(j)) cost_q[i][j] <= bus.Cost;
        end
    end

    assign bus.W          = w_q;
    assign bus.J          = j_q;
    assign bus.BUSY       = busy_q;
    assign bus.Valid      = valid_q;
    assign bus.MinCost    = min_out_q;
    assign bus.MatchCount = cnt_out_q;
    assign bus.BestJob    = best_out_q;

endmodule

// File: tb/tb_jam_param.sv
// Directed bench: three solver instances (N=8/MCW=16, N=8/MCW=4, N=4) plus the
// standalone permutation stepper, each fed from a small combinational cost model.
module tb_jam_param;

    logic        clk = 1'b0;
    logic        rstA, rstB, rstC;
    logic [6:0]  valB;
    logic        antiC;
    logic [7:0]  pp, pn;
    logic        pl;
    logic [7:0]  exp_perm [24];
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    jam_param_if #(.N(8), .CW(7), .MCW(16)) ifA ();
    jam_param_if #(.N(8), .CW(7), .MCW(4))  ifB ();
    jam_param_if #(.N(4), .CW(7), .MCW(16)) ifC ();

    jam_param #(.N(8), .CW(7), .MCW(16)) uA (.CLK(clk), .RST(rstA), .bus(ifA));
    jam_param #(.N(8), .CW(7), .MCW(4))  uB (.CLK(clk), .RST(rstB), .bus(ifB));
    jam_param #(.N(4), .CW(7), .MCW(16)) uC (.CLK(clk), .RST(rstC), .bus(ifC));

    jam_next_perm #(.N(4), .IW(2)) uP (.perm_i(pp), .perm_o(pn), .last_o(pl));

    always_comb ifA.Cost = (ifA.W == ifA.J) ? 7'd1 : 7'd10;
    always_comb ifB.Cost = valB;
    always_comb begin
        if (antiC) ifC.Cost = (({1'b0, ifC.W} + {1'b0, ifC.J}) == 3'd3) ? 7'd1 : 7'd10;
        else       ifC.Cost = 7'd5;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned ne, vA, vB, nvA, nvB, nvC;

        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        ifA.START = 1'b0; ifB.START = 1'b0; ifC.START = 1'b0;
        valB = 7'd0; antiC = 1'b0; pp = 8'h00;

        // Lexicographic reference list built by brute-force enumeration.
        ne = 0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int d = 0; d < 4; d++)
                        if (a != b && a != c && a != d && b != c && b != d && c != d && ne < 24) begin
                            exp_perm[ne] = {2'(d), 2'(c), 2'(b), 2'(a)};
                            ne++;
                        end
        for (int i = 0; i < 24; i++) begin
            pp = exp_perm[i];
            #1;
            chk("np_last", pl, (i == 23));
            if (i < 23) chk("np_next", pn, exp_perm[i+1]);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("A_rst_valid", ifA.Valid, 0);
        chk("A_rst_busy", ifA.BUSY, 0);
        chk("A_rst_mincost", ifA.MinCost, 0);
        chk("A_rst_count", ifA.MatchCount, 0);
        chk("A_rst_best", ifA.BestJob, 0);
        chk("A_rst_w", ifA.W, 0);
        chk("A_rst_j", ifA.J, 0);
        chk("B_rst_count", ifB.MatchCount, 0);
        chk("C_rst_busy", ifC.BUSY, 0);
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;

        @(posedge clk);
        #1;
        ifA.START = 1'b1; ifB.START = 1'b1; ifC.START = 1'b1;
        @(posedge clk);
        vA = 0; vB = 0; nvA = 0; nvB = 0; nvC = 0;
        for (int c = 0; c <= 40390; c++) begin
            #1;
            if (c == 0) begin
                chk("A_busy_on_start", ifA.BUSY, 1);
                ifA.START = 1'b0; ifB.START = 1'b0; ifC.START = 1'b0;
            end
            if (c < 64) begin
                chk("A_W_sweep", ifA.W, c / 8);
                chk("A_J_sweep", ifA.J, c % 8);
            end
            if (ifA.Valid) begin nvA++; vA = c; end
            if (ifB.Valid) begin nvB++; vB = c; end
            if (ifC.Valid) begin
                nvC++;
                if (nvC == 1) begin
                    chk("C1_valid_cycle", c, 41);
                    chk("C1_mincost", ifC.MinCost, 20);
                    chk("C1_count", ifC.MatchCount, 24);
                    chk("C1_best", ifC.BestJob, 8'hE4);
                    chk("C1_busy_rerun", ifC.BUSY, 1);
                    ifC.START = 1'b0;
                end else begin
                    chk("C2_valid_cycle", c, 82);
                    chk("C2_mincost", ifC.MinCost, 4);
                    chk("C2_count", ifC.MatchCount, 1);
                    chk("C2_best", ifC.BestJob, 8'h1B);
                    chk("C2_busy", ifC.BUSY, 0);
                end
            end
            if (c == 10) ifC.START = 1'b1;
            if (c == 11) ifC.START = 1'b0;
            if (c == 30) begin antiC = 1'b1; ifC.START = 1'b1; end
            @(posedge clk);
        end
        chk("A_valid_cycle", vA, 40385);
        chk("A_valid_pulses", nvA, 1);
        chk("A_mincost", ifA.MinCost, 8);
        chk("A_count", ifA.MatchCount, 1);
        chk("A_best", ifA.BestJob, 24'o76543210);
        chk("A_busy_after", ifA.BUSY, 0);
        chk("B0_valid_cycle", vB, 40385);
        chk("B0_mincost", ifB.MinCost, 0);
        chk("B0_count_sat", ifB.MatchCount, 15);
        chk("B0_best", ifB.BestJob, 24'o76543210);
        chk("C_valid_pulses", nvC, 2);

        #1;
        valB = 7'd127;
        ifA.START = 1'b1; ifB.START = 1'b1;
        @(posedge clk);
        vA = 0; vB = 0; nvA = 0; nvB = 0;
        for (int c = 0; c <= 40495; c++) begin
            #1;
            if (c == 0) begin ifA.START = 1'b0; ifB.START = 1'b0; end
            if (ifA.Valid) begin nvA++; vA = c; end
            if (ifB.Valid) begin nvB++; vB = c; end
            if (c == 100) begin
                chk("A_busy_mid_eval", ifA.BUSY, 1);
                rstA = 1'b0;
            end
            if (c == 101) begin
                chk("A_abort_valid", ifA.Valid, 0);
                chk("A_abort_busy", ifA.BUSY, 0);
                chk("A_abort_mincost", ifA.MinCost, 0);
                chk("A_abort_count", ifA.MatchCount, 0);
                chk("A_abort_best", ifA.BestJob, 0);
                chk("A_abort_w", ifA.W, 0);
                chk("A_abort_j", ifA.J, 0);
                rstA = 1'b1;
            end
            if (c == 105) ifA.START = 1'b1;
            if (c == 106) ifA.START = 1'b0;
            @(posedge clk);
        end
        chk("A2_valid_cycle", vA, 106 + 40385);
        chk("A2_valid_pulses", nvA, 1);
        chk("A2_mincost", ifA.MinCost, 8);
        chk("A2_count", ifA.MatchCount, 1);
        chk("A2_best", ifA.BestJob, 24'o76543210);
        chk("B1_valid_cycle", vB, 40385);
        chk("B1_valid_pulses", nvB, 1);
        chk("B1_mincost", ifB.MinCost, 1016);
        chk("B1_count_sat", ifB.MatchCount, 15);
        chk("B1_best", ifB.BestJob, 24'o76543210);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
